// File: rtl/ram_pkg.sv
// Shared helpers for the single-port byte-enable RAM block.
//   be_w()       : byte lanes for a given data width
//   fifo_depth() : response FIFO entries for a given read latency
//   rd_lat_ok()  : legal read-latency values
//   be_merge()   : per-lane merge of new write data over the old word
package ram_pkg;

  // Widest word be_merge can handle; callers zero-extend into it.
  localparam int unsigned MAX_DATA_W = 1024;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned rd_lat);
    return rd_lat + 1;
  endfunction

  function automatic bit rd_lat_ok(input int unsigned rd_lat);
    return (rd_lat == 1) || (rd_lat == 2);
  endfunction

  // Lanes with be[i]=1 take new_word, all others keep old_word.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(MAX_BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_sp_be_pipe_if.sv
// Request/response bus of ram_sp_be_pipe.
//   master : request issuer / response consumer
//   slave  : the RAM
interface ram_sp_be_pipe_if
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 18
);
  localparam int unsigned BE_W = be_w(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [BE_W-1:0]   req_be;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_rsp_fifo.sv
// Fall-through response FIFO: head entry is visible as soon as it is stored.
//   push/push_data : write an entry (caller guarantees not full)
//   pop            : drop the head entry (ignored when empty)
//   pop_data       : head entry, meaningful only when !empty
//   empty/count    : occupancy
module ram_rsp_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_eff_c;

  // Circular increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count == '0);
  assign pop_eff_c = pop && !empty;
  assign pop_data  = store[rd_ptr];

  // Storage needs no reset: entries are only observed once counted.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)      wr_ptr <= ptr_inc(wr_ptr);
      if (pop_eff_c) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop_eff_c);
    end
  end
endmodule

// File: rtl/ram_sp_be_pipe.sv
// Single-port synchronous SRAM with byte-lane writes, 1- or 2-cycle read
// latency, credit-limited request acceptance and a fall-through response FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request (valid/ready, we, addr, be, wdata) and
//                response (valid/ready, rdata, err) channels
module ram_sp_be_pipe
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DEPTH  = 262144,
  parameter int unsigned RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_sp_be_pipe_if.slave bus
);
  localparam int unsigned BE_W       = be_w(DATA_W);
  localparam int unsigned FIFO_DEPTH = fifo_depth(RD_LAT);
  localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W      = CNT_W + 1;
  localparam int unsigned ENT_W      = DATA_W + 1;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("ram_sp_be_pipe: RD_LAT must be 1 or 2");
  end
  if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("ram_sp_be_pipe: DATA_W must be a multiple of 8 and <= MAX_DATA_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_ready_q;
  logic              acc_c;
  logic              rd_acc_c;
  logic              wr_acc_c;
  logic              in_range_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] rd_word_c;
  logic              rd_err_c;
  logic              push_c;
  logic [ENT_W-1:0]  push_ent_c;
  logic              inflight_c;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  head_ent;
  logic              pop_c;
  logic [OUT_W-1:0]  out_nxt_c;

  // Request decode.
  assign acc_c      = bus.req_valid && req_ready_q;
  assign rd_acc_c   = acc_c && !bus.req_we;
  assign wr_acc_c   = acc_c && bus.req_we;
  assign in_range_c = 64'(bus.req_addr) < 64'(DEPTH);
  assign idx_c      = IDX_W'(bus.req_addr);
  assign rd_err_c   = !in_range_c;

  // Out-of-range reads return zero data rather than an aliased word.
  always_comb begin
    rd_word_c = '0;
    if (in_range_c) rd_word_c = mem[idx_c];
  end

  // Array write port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_acc_c && in_range_c) begin
      mem[idx_c] <= DATA_W'(be_merge(MAX_DATA_W'(mem[idx_c]),
                                     MAX_DATA_W'(bus.req_wdata),
                                     MAX_BE_W'(bus.req_be)));
    end
  end

  // Read pipeline: at RD_LAT=1 the FIFO entry itself is the array register;
  // RD_LAT=2 adds one array register in front of it.
  if (RD_LAT == 2) begin : g_lat2
    logic             s1_valid;
    logic [ENT_W-1:0] s1_ent;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_ent   <= '0;
      end else begin
        s1_valid <= rd_acc_c;
        s1_ent   <= {rd_err_c, rd_word_c};
      end
    end

    assign push_c     = s1_valid;
    assign push_ent_c = s1_ent;
    assign inflight_c = s1_valid;
  end else begin : g_lat1
    assign push_c     = rd_acc_c;
    assign push_ent_c = {rd_err_c, rd_word_c};
    assign inflight_c = 1'b0;
  end

  ram_rsp_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_ent_c),
    .pop       (pop_c),
    .pop_data  (head_ent),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pop_c = !fifo_empty && bus.rsp_ready;

  // Credits outstanding after this edge; a pop only frees a credit next cycle.
  assign out_nxt_c = OUT_W'(fifo_count) + OUT_W'(inflight_c)
                   + OUT_W'(rd_acc_c) - OUT_W'(pop_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_ready_q <= 1'b0;
    else        req_ready_q <= out_nxt_c < OUT_W'(FIFO_DEPTH);
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_rdata = fifo_empty ? '0 : head_ent[DATA_W-1:0];
  assign bus.rsp_err   = !fifo_empty && head_ent[DATA_W];
endmodule

// File: tb/tb_ram_sp_be_pipe.sv
// Directed bench for ram_sp_be_pipe (DEPTH=1000, RD_LAT=1).
module tb_ram_sp_be_pipe;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 18;
  localparam int unsigned DEPTH      = 1000;
  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned FIFO_DEPTH = RD_LAT + 1;

  typedef struct {
    bit          we;
    logic [17:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ram_sp_be_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_sp_be_pipe #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Present one request and hold it until accepted; returns just after the accepting edge.
  task automatic issue(input bit we, input logic [17:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata);
    int n;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready stuck at %b", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Read, measure latency to rsp_valid, check data/err, and check the pop.
  task automatic read_check(input string name, input logic [17:0] addr,
                            input logic [31:0] exp_data, input bit exp_err);
    int lat;
    bus.rsp_ready = 1'b1;
    issue(1'b0, addr, 4'h0, 32'h0);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(RD_LAT));
    check({name, "_data"}, 64'(bus.rsp_rdata), 64'(exp_data));
    check({name, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
    @(posedge clk); #1;
    check({name, "_popped"}, 64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    int nxt, exp_k, bad, drops, first, last, acc, unstable, got, extra;
    logic [31:0] held;
    bit held_seen;

    vecs.push_back('{1'b1, 18'h00010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, "wr_deadbeef"});
    vecs.push_back('{1'b0, 18'h00010, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, "rd_deadbeef"});
    vecs.push_back('{1'b1, 18'h00020, 4'hF, 32'h11223344, 32'h0,        1'b0, "wr_full"});
    vecs.push_back('{1'b1, 18'h00020, 4'h5, 32'hAABBCCDD, 32'h0,        1'b0, "wr_be5"});
    vecs.push_back('{1'b0, 18'h00020, 4'h0, 32'h0,        32'h11BB33DD, 1'b0, "rd_be5"});
    vecs.push_back('{1'b1, 18'h00030, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0, "wr_cafe"});
    vecs.push_back('{1'b1, 18'h00030, 4'h0, 32'h12345678, 32'h0,        1'b0, "wr_be0"});
    vecs.push_back('{1'b0, 18'h00030, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0, "rd_be0_noop"});
    vecs.push_back('{1'b1, 18'h00040, 4'hF, 32'h00000000, 32'h0,        1'b0, "wr_zero"});
    vecs.push_back('{1'b1, 18'h00040, 4'h8, 32'hA5A5A5A5, 32'h0,        1'b0, "wr_be8"});
    vecs.push_back('{1'b0, 18'h00040, 4'h0, 32'h0,        32'hA5000000, 1'b0, "rd_be8"});
    vecs.push_back('{1'b1, 18'd999,   4'hF, 32'h99999999, 32'h0,        1'b0, "wr_999"});
    vecs.push_back('{1'b1, 18'd1000,  4'hF, 32'hFFFFFFFF, 32'h0,        1'b0, "wr_oor"});
    vecs.push_back('{1'b0, 18'd1000,  4'h0, 32'h0,        32'h0,        1'b1, "rd_oor"});
    vecs.push_back('{1'b0, 18'd999,   4'h0, 32'h0,        32'h99999999, 1'b0, "rd_999"});
    vecs.push_back('{1'b1, 18'd5,     4'hF, 32'h00000055, 32'h0,        1'b0, "wr_5"});
    vecs.push_back('{1'b1, 18'd1029,  4'hF, 32'hFFFFFFFF, 32'h0,        1'b0, "wr_oor_alias"});
    vecs.push_back('{1'b0, 18'd5,     4'h0, 32'h0,        32'h00000055, 1'b0, "rd_5_no_alias"});
    vecs.push_back('{1'b0, 18'h3FFFF, 4'h0, 32'h0,        32'h0,        1'b1, "rd_max_addr"});

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    check("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    #1 rst_n = 1'b1;
    #1 check("rel_ready_before_clk", 64'(bus.req_ready), 64'(0));
    @(posedge clk); #1;
    check("rel_ready_after_clk", 64'(bus.req_ready), 64'(1));

    // Directed table
    foreach (vecs[i]) begin
      if (vecs[i].we) issue(1'b1, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      else read_check(vecs[i].name, vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Preload mem[k]=k, then stream 100 reads with rsp_ready high
    for (int k = 0; k < 100; k++) issue(1'b1, 18'(k), 4'hF, 32'(k));
    bus.rsp_ready = 1'b1;
    nxt = 0; exp_k = 0; bad = 0; drops = 0; first = -1; last = -1;
    for (int c = 0; c < 130; c++) begin
      bus.req_valid = (nxt < 100);
      bus.req_we    = 1'b0;
      bus.req_addr  = 18'(nxt);
      if (nxt < 100 && bus.req_ready !== 1'b1) drops++;
      if (bus.rsp_valid === 1'b1) begin
        if (bus.rsp_rdata !== 32'(exp_k) || bus.rsp_err !== 1'b0) bad++;
        if (first < 0) first = c;
        last = c;
        exp_k++;
      end
      if (bus.req_valid && bus.req_ready === 1'b1) nxt++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    check("stream_ready_drops", 64'(drops), 64'(0));
    check("stream_order_errs", 64'(bad), 64'(0));
    check("stream_rsp_count", 64'(exp_k), 64'(100));
    check("stream_one_per_cycle", 64'(last - first), 64'(99));

    // Back-pressure: only FIFO_DEPTH reads accepted, head stable while stalled
    bus.rsp_ready = 1'b0;
    nxt = 10; acc = 0; unstable = 0; held = '0; held_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 18'(nxt);
      if (bus.rsp_valid === 1'b1) begin
        if (!held_seen) begin held = bus.rsp_rdata; held_seen = 1'b1; end
        else if (bus.rsp_rdata !== held) unstable++;
      end
      if (bus.req_ready === 1'b1) begin acc++; nxt++; end
      @(posedge clk); #1;
    end
    check("stall_accepts", 64'(acc), 64'(FIFO_DEPTH));
    check("stall_req_ready", 64'(bus.req_ready), 64'(0));
    check("stall_head", 64'(held), 64'(10));
    check("stall_stable", 64'(unstable), 64'(0));

    // Release: remaining reads 10..15 drain in order, no loss or duplication
    bus.rsp_ready = 1'b1;
    got = 0; bad = 0; extra = 0;
    for (int c = 0; c < 40; c++) begin
      bus.req_valid = (nxt < 16);
      bus.req_addr  = 18'(nxt);
      if (bus.rsp_valid === 1'b1) begin
        if (got < 6) begin
          if (bus.rsp_rdata !== 32'(10 + got)) bad++;
        end else extra++;
        got++;
      end
      if (bus.req_valid && bus.req_ready === 1'b1) nxt++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    check("drain_order_errs", 64'(bad), 64'(0));
    check("drain_count", 64'(got), 64'(6));
    check("drain_extra", 64'(extra), 64'(0));

    // Asynchronous reset with reads outstanding
    issue(1'b1, 18'h00050, 4'hF, 32'h5A5A1234);
    bus.rsp_ready = 1'b0;
    issue(1'b0, 18'h00050, 4'h0, 32'h0);
    issue(1'b0, 18'h00051, 4'h0, 32'h0);
    check("pre_rst_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("mid_rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'(1));
    bus.rsp_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.rsp_valid === 1'b1) extra++;
      @(posedge clk); #1;
    end
    check("post_rst_stale_rsp", 64'(extra), 64'(0));
    read_check("post_rst_mem", 18'h00050, 32'h5A5A1234, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
